// File: rtl/fifo_pkg.sv
// Shared types and constants for the FIFO burst reader and its skid buffer.
package fifo_pkg;

    // Burst reader control states.
    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_RUN   = 2'd1,
        ST_DRAIN = 2'd2,
        ST_DONE  = 2'd3
    } state_e;

    // Skid buffer depth; also the ceiling on buffered + in-flight words.
    localparam int SKID_DEPTH = 2;

    // Width of the skid occupancy count (0..SKID_DEPTH).
    localparam int OCC_W = $clog2(SKID_DEPTH + 1);

endpackage

// File: rtl/fifo_burst_reader_if.sv
// Control, FIFO pop port and output stream of the burst reader.
interface fifo_burst_reader_if #(
    parameter int WIDTH = 8,
    parameter int LEN_W = 16
);
    logic             start;
    logic [LEN_W-1:0] len;
    logic             fifo_empty;
    logic [WIDTH-1:0] fifo_dout;
    logic             fifo_pop;
    logic             m_valid;
    logic [WIDTH-1:0] m_data;
    logic             m_last;
    logic             m_ready;
    logic             busy;
    logic             done;

    // The reader drives pops and the output stream.
    modport master (
        input  start, len, fifo_empty, fifo_dout, m_ready,
        output fifo_pop, m_valid, m_data, m_last, busy, done
    );

    // The surrounding logic: command source, FIFO and downstream sink.
    modport slave (
        output start, len, fifo_empty, fifo_dout, m_ready,
        input  fifo_pop, m_valid, m_data, m_last, busy, done
    );
endinterface

// File: rtl/fifo_burst_reader_skid2.sv
// Two-entry registered valid/ready buffer. The writer must never push into a
// full buffer without a simultaneous pop; it uses occ to guarantee that.
module stream_skid2
    import fifo_pkg::*;
#(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             in_valid,
    input  logic [WIDTH-1:0] in_data,
    output logic             out_valid,
    output logic [WIDTH-1:0] out_data,
    input  logic             out_ready,
    output logic [OCC_W-1:0] occ
);
    logic [WIDTH-1:0] ent0_q, ent0_d;
    logic [WIDTH-1:0] ent1_q, ent1_d;
    logic [OCC_W-1:0] occ_q, occ_d;
    logic             take;

    // Next-state of the head/tail entries; the head is always ent0.
    always_comb begin
        ent0_d = ent0_q;
        ent1_d = ent1_q;
        occ_d  = occ_q;
        take   = (occ_q != '0) && out_ready;
        if (occ_q == OCC_W'(0)) begin
            if (in_valid) begin
                ent0_d = in_data;
                occ_d  = OCC_W'(1);
            end
        end else if (occ_q == OCC_W'(1)) begin
            if (in_valid && take) begin
                ent0_d = in_data;
            end else if (in_valid) begin
                ent1_d = in_data;
                occ_d  = OCC_W'(2);
            end else if (take) begin
                occ_d  = OCC_W'(0);
            end
        end else begin
            if (take) begin
                ent0_d = ent1_q;
                if (in_valid) ent1_d = in_data;
                else          occ_d  = OCC_W'(1);
            end
        end
    end

    // Buffer registers.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            ent0_q <= '0;
            ent1_q <= '0;
            occ_q  <= '0;
        end else begin
            ent0_q <= ent0_d;
            ent1_q <= ent1_d;
            occ_q  <= occ_d;
        end
    end

    assign out_valid = (occ_q != '0);
    assign out_data  = ent0_q;
    assign occ       = occ_q;

endmodule

// File: rtl/fifo_burst_reader.sv
// Pops a fixed-length burst from a registered-read FIFO and presents it as a
// framed valid/ready stream, hiding the read latency behind a 2-entry skid.
module fifo_burst_reader
    import fifo_pkg::*;
#(
    parameter int WIDTH = 8,
    parameter int LEN_W = 16
) (
    input  logic                 clk,
    input  logic                 reset,
    fifo_burst_reader_if.master  bus
);
    state_e           state_q, state_d;
    logic [LEN_W-1:0] pop_rem_q, pop_rem_d;
    logic [LEN_W-1:0] beat_rem_q, beat_rem_d;
    logic             inflight_q, inflight_d;

    logic [OCC_W-1:0] occ;
    logic [OCC_W-1:0] credit;
    logic             skid_valid;
    logic [WIDTH-1:0] skid_data;
    logic             accept;
    logic             pop;

    // Buffered words plus the one possibly in flight from the FIFO.
    assign credit = occ + {{(OCC_W-1){1'b0}}, inflight_q};
    assign accept = skid_valid && bus.m_ready;

    // A pop is only issued when its word is guaranteed a skid slot on arrival;
    // at full credit that slot is the one freed by this cycle's accept.
    assign pop = (state_q == ST_RUN) && (pop_rem_q != '0) && !bus.fifo_empty &&
                 ((credit < OCC_W'(SKID_DEPTH)) ||
                  ((credit == OCC_W'(SKID_DEPTH)) && accept));

    // FSM next-state, burst counters and in-flight tracking.
    always_comb begin
        state_d    = state_q;
        pop_rem_d  = pop_rem_q;
        beat_rem_d = beat_rem_q;
        inflight_d = pop;
        unique case (state_q)
            ST_IDLE: begin
                if (bus.start) begin
                    pop_rem_d  = bus.len;
                    beat_rem_d = bus.len;
                    state_d    = (bus.len != '0) ? ST_RUN : ST_DONE;
                end
            end
            ST_RUN: begin
                if (pop_rem_q == '0) state_d = ST_DRAIN;
            end
            ST_DRAIN: begin
                if (accept && (beat_rem_q == LEN_W'(1))) state_d = ST_DONE;
            end
            ST_DONE: state_d = ST_IDLE;
            default: state_d = ST_IDLE;
        endcase
        if (pop) pop_rem_d = pop_rem_q - LEN_W'(1);
        if (accept && (beat_rem_q != '0)) beat_rem_d = beat_rem_q - LEN_W'(1);
    end

    // State and counter registers.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q    <= ST_IDLE;
            pop_rem_q  <= '0;
            beat_rem_q <= '0;
            inflight_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            pop_rem_q  <= pop_rem_d;
            beat_rem_q <= beat_rem_d;
            inflight_q <= inflight_d;
        end
    end

    // The FIFO's read data is valid exactly when the previous cycle popped.
    stream_skid2 #(.WIDTH(WIDTH)) u_skid (
        .clk       (clk),
        .reset     (reset),
        .in_valid  (inflight_q),
        .in_data   (bus.fifo_dout),
        .out_valid (skid_valid),
        .out_data  (skid_data),
        .out_ready (bus.m_ready),
        .occ       (occ)
    );

    assign bus.fifo_pop = pop;
    assign bus.m_valid  = skid_valid;
    assign bus.m_data   = skid_data;
    assign bus.m_last   = skid_valid && (beat_rem_q == LEN_W'(1));
    assign bus.busy     = (state_q == ST_RUN) || (state_q == ST_DRAIN);
    assign bus.done     = (state_q == ST_DONE);

endmodule
